pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS datapath: holds the PC register and selects the next PC from sequential, conditional-branch, jump, jump-register and exception-return sources. Adds stall hold, exception redirect with an EPC register, misaligned-jump detection and an optional return-address stack (RAS). It sits at the head of the fetch stage, driving the instruction-memory address and taking control from the decoder and ALU.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 67 ++++++
 rtl/pc_unit.sv | 148 ++++++++++++++
 tb/tb_pc_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings,
// default reset/exception addresses and the branch-decision helper.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_J    = 3'd2,
    PC_JR   = 3'd3,
    PC_ERET = 3'd4
  } pcsel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

  // BNE branches on a non-zero comparison, BEQ on a zero one.
  function automatic logic br_taken(input logic br_ne, input logic zero);
    return br_ne ? ~zero : zero;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_unit: circular storage, write pointer and
// saturating occupancy count. Pop+push in one cycle replaces the top entry.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // ptr_q is the next free slot; the power-of-two depth makes it wrap for free.
  assign top_idx = ptr_q - PTR_W'(1);
  assign valid_o = (cnt_q != '0);
  assign top_o   = valid_o ? mem_q[top_idx] : '0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (pop_i && push_i && valid_o) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && valid_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: next-PC selection, stall hold,
// exception redirect with EPC, misaligned-JR trap. Return-address stack under PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEFAULT_EXC_VEC),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall_i,
  input  logic [2:0]       pcsel_i,
  input  logic             br_ne_i,
  input  logic             zero_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic [25:0]      target_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic             link_i,
  input  logic             ret_i,
  input  logic             exc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc4_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             redirect_o,
  output logic             adel_o,
  output logic [WIDTH-1:0] ras_top_o,
  output logic             ras_valid_o,
  output logic             ras_miss_o
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redirect_q, redirect_d;
  logic             adel_q, adel_d;
  logic             ras_miss_q, ras_miss_d;

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] j_target;
  logic             jr_misaligned;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_valid;

  assign pc4           = pc_q + WIDTH'(4);
  assign j_target      = {pc_q[WIDTH-1:28], target_i, 2'b00};
  assign jr_misaligned = (pcsel_i == PC_JR) && (rs_i[1:0] != 2'b00);

  // Exceptions and misaligned JR both bypass the stall; RAS moves only on a normal advance.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    adel_d     = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (exc_i) begin
      epc_d      = pc_q;
      pc_d       = EXC_VEC;
      redirect_d = 1'b1;
    end else if (jr_misaligned) begin
      epc_d      = pc_q;
      pc_d       = EXC_VEC;
      redirect_d = 1'b1;
      adel_d     = 1'b1;
    end else if (!stall_i) begin
      case (pcsel_i)
        PC_BR: begin
          if (br_taken(br_ne_i, zero_i)) begin
            pc_d       = br_target_i;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc4;
          end
        end
        PC_J: begin
          pc_d       = j_target;
          redirect_d = 1'b1;
          ras_push   = link_i;
        end
        PC_JR: begin
          pc_d       = rs_i;
          redirect_d = 1'b1;
          ras_push   = link_i;
          ras_pop    = ret_i;
        end
        PC_ERET: begin
          pc_d       = epc_q;
          redirect_d = 1'b1;
        end
        default: pc_d = pc4;
      endcase
    end
  end

`ifdef PC_RAS_EN
  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc4),
    .top_o   (ras_top),
    .valid_o (ras_valid)
  );

  // The top is compared before the pop takes effect at the edge.
  assign ras_miss_d = ras_pop && (!ras_valid || (ras_top != rs_i));
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_ctl;

  assign unused_ras_ctl = ras_push ^ ras_pop;
  assign ras_top        = '0;
  assign ras_valid      = 1'b0;
  assign ras_miss_d     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      adel_q     <= 1'b0;
      ras_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      adel_q     <= adel_d;
      ras_miss_q <= ras_miss_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc4_o       = pc4;
  assign epc_o       = epc_q;
  assign redirect_o  = redirect_q;
  assign adel_o      = adel_q;
  assign ras_top_o   = ras_top;
  assign ras_valid_o = ras_valid;
  assign ras_miss_o  = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random stimulus
// compared every cycle against a queue-based reference model.
module tb_pc_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC    = 32'h0000_4180;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_i, br_ne_i, zero_i, link_i, ret_i, exc_i;
  logic [2:0]  pcsel_i;
  logic [31:0] br_target_i, rs_i;
  logic [25:0] target_i;
  logic [31:0] pc_o, pc4_o, epc_o, ras_top_o;
  logic        redirect_o, adel_o, ras_valid_o, ras_miss_o;

  pc_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall_i     (stall_i),
    .pcsel_i     (pcsel_i),
    .br_ne_i     (br_ne_i),
    .zero_i      (zero_i),
    .br_target_i (br_target_i),
    .target_i    (target_i),
    .rs_i        (rs_i),
    .link_i      (link_i),
    .ret_i       (ret_i),
    .exc_i       (exc_i),
    .pc_o        (pc_o),
    .pc4_o       (pc4_o),
    .epc_o       (epc_o),
    .redirect_o  (redirect_o),
    .adel_o      (adel_o),
    .ras_top_o   (ras_top_o),
    .ras_valid_o (ras_valid_o),
    .ras_miss_o  (ras_miss_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_pc, m_epc;
  bit          m_redir, m_adel, m_miss;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_epc   = '0;
    m_redir = 1'b0;
    m_adel  = 1'b0;
    m_miss  = 1'b0;
    m_ras.delete();
  endtask

  task automatic ras_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endtask

  task automatic model_step();
    logic [31:0] pc4, npc, nepc;
    bit redir, adel, miss;
    pc4 = m_pc + 32'd4;
    npc = m_pc; nepc = m_epc;
    redir = 0; adel = 0; miss = 0;
    if (exc_i) begin
      nepc = m_pc; npc = EXC; redir = 1;
    end else if (pcsel_i == 3'd3 && rs_i[1:0] != 2'b00) begin
      nepc = m_pc; npc = EXC; redir = 1; adel = 1;
    end else if (!stall_i) begin
      case (pcsel_i)
        3'd1: begin
          if (br_ne_i ? !zero_i : zero_i) begin npc = br_target_i; redir = 1; end
          else npc = pc4;
        end
        3'd2: begin
          npc = {m_pc[31:28], target_i, 2'b00}; redir = 1;
          if (RAS_ON && link_i) ras_push(pc4);
        end
        3'd3: begin
          npc = rs_i; redir = 1;
          if (RAS_ON && ret_i) begin
            if (m_ras.size() == 0) miss = 1;
            else begin
              if (m_ras[$] != rs_i) miss = 1;
              void'(m_ras.pop_back());
            end
          end
          if (RAS_ON && link_i) ras_push(pc4);
        end
        3'd4: begin npc = m_epc; redir = 1; end
        default: npc = pc4;
      endcase
    end
    m_pc = npc; m_epc = nepc; m_redir = redir; m_adel = adel; m_miss = miss;
  endtask

  task automatic check_all();
    check("pc", pc_o, m_pc);
    check("pc4", pc4_o, m_pc + 32'd4);
    check("epc", epc_o, m_epc);
    check("redirect", 32'(redirect_o), 32'(m_redir));
    check("adel", 32'(adel_o), 32'(m_adel));
    check("ras_top", ras_top_o, (m_ras.size() != 0) ? m_ras[$] : 32'h0);
    check("ras_valid", 32'(ras_valid_o), 32'(m_ras.size() != 0));
    check("ras_miss", 32'(ras_miss_o), 32'(m_miss));
  endtask

  task automatic clear_inputs();
    stall_i = 0; pcsel_i = 3'd0; br_ne_i = 0; zero_i = 0; br_target_i = '0;
    target_i = '0; rs_i = '0; link_i = 0; ret_i = 0; exc_i = 0;
  endtask

  // Inputs are driven at edge+1; outputs are sampled at the following edge+1.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic go(input logic [2:0] sel, input logic [31:0] rs, input logic lnk,
                    input logic ret, input logic [25:0] tgt);
    clear_inputs();
    pcsel_i = sel; rs_i = rs; link_i = lnk; ret_i = ret; target_i = tgt;
    cycle();
  endtask

  task automatic async_reset();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_pc_now", pc_o, RST_PC);
    @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      go(3'd0, 0, 0, 0, 0);
      check("seq_pc", pc_o, RST_PC + 32'(4 * i));
    end
    go(3'd0, 0, 0, 0, 0);

    // BEQ taken, then BNE not taken
    clear_inputs(); pcsel_i = 3'd1; zero_i = 1; br_target_i = 32'h3100; cycle();
    check("beq_pc", pc_o, 32'h3100);
    check("beq_redir", 32'(redirect_o), 32'd1);
    go(3'd0, 0, 0, 0, 0);
    go(3'd3, 32'h3010, 0, 0, 0);
    clear_inputs(); pcsel_i = 3'd1; zero_i = 1; br_ne_i = 1; br_target_i = 32'h3100; cycle();
    check("bne_pc", pc_o, 32'h3014);

    // Exception during stall, then ERET
    go(3'd3, 32'h3020, 0, 0, 0);
    clear_inputs(); stall_i = 1; exc_i = 1; cycle();
    check("exc_epc", epc_o, 32'h3020);
    check("exc_pc", pc_o, EXC);
    go(3'd4, 0, 0, 0, 0);
    check("eret_pc", pc_o, 32'h3020);

    // Misaligned JR
    go(3'd3, 32'h3040, 0, 0, 0);
    go(3'd3, 32'h3102, 0, 0, 0);
    check("adel", 32'(adel_o), 32'd1);
    check("adel_epc", epc_o, 32'h3040);

    // Five JALs overflow a 4-entry stack; then a matching and a wrong return
    go(3'd3, 32'h3000, 0, 0, 0);
    for (int i = 1; i <= 5; i++) go(3'd2, 0, 1, 0, 26'((32'h3000 + 32'(16 * i)) >> 2));
    check("ras_top5", ras_top_o, RAS_ON ? 32'h3044 : 32'h0);
    go(3'd3, 32'h3044, 0, 1, 0);
    check("ret_hit", 32'(ras_miss_o), 32'd0);
    go(3'd3, 32'h9998, 0, 1, 0);
    check("ret_miss", 32'(ras_miss_o), 32'(RAS_ON));

    // Asynchronous reset while stalled
    go(3'd3, 32'h3100, 0, 0, 0);
    clear_inputs(); stall_i = 1; cycle();
    async_reset();

    // Random phase
    for (int n = 0; n < 800; n++) begin
      clear_inputs();
      pcsel_i     = 3'($urandom_range(0, 7));
      exc_i       = ($urandom % 16) == 0;
      stall_i     = ($urandom % 5) == 0;
      br_ne_i     = 1'($urandom);
      zero_i      = 1'($urandom);
      br_target_i = $urandom;
      target_i    = 26'($urandom);
      link_i      = 1'($urandom);
      ret_i       = 1'($urandom);
      case ($urandom % 4)
        0: rs_i = $urandom;
        1: rs_i = (m_ras.size() != 0) ? m_ras[$] : {$urandom, 2'b00} >> 2 << 2;
        default: rs_i = $urandom & 32'hFFFF_FFFC;
      endcase
      cycle();
      if (n % 200 == 199) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
